// File: rtl/mean_pkg.sv
// Shared types and helpers for the streaming MEAN reduction unit and its divider.
package mean_pkg;

  typedef enum logic [2:0] {IDLE, ACCUM, DIVIDE, OUTPUT, DONE} state_t;

  // Accumulator width: room for 2^CNT_W-1 worst-case elements, plus one bit when zero points widen the element.
  function automatic int acc_w_f(input int data_w, input int cnt_w, input bit zp_en);
    return data_w + cnt_w + (zp_en ? 1 : 0);
  endfunction

  // Half of the divisor, added to the magnitude for round-half-away-from-zero.
  function automatic longint rnd_half(input longint n);
    return n >>> 1;
  endfunction

  function automatic longint sat_narrow(input longint v, input int w);
    longint hi, lo;
    hi = (longint'(1) <<< (w - 1)) - 1;
    lo = -hi - 1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/mean_div_seq.sv
// Unsigned restoring divider, one quotient bit per cycle; ACC_W iterations after a load cycle.
module mean_div_seq #(
  parameter int ACC_W = 24,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [ACC_W-1:0] dividend,
  input  logic [CNT_W-1:0] divisor,
  output logic [ACC_W-1:0] quotient,
  output logic             done
);
  localparam int CW = $clog2(ACC_W + 1);

  logic [CNT_W-1:0] rem;
  logic [CW-1:0]    cnt;
  logic             run;
  logic [CNT_W:0]   sh, diff;
  logic             ge;

  // Quotient register doubles as the dividend shift register.
  assign sh   = {rem, quotient[ACC_W-1]};
  assign ge   = sh >= {1'b0, divisor};
  assign diff = sh - {1'b0, divisor};
  assign done = run && (cnt == CW'(1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rem      <= '0;
      quotient <= '0;
      cnt      <= '0;
      run      <= 1'b0;
    end else if (start) begin
      rem      <= '0;
      quotient <= dividend;
      cnt      <= CW'(ACC_W);
      run      <= 1'b1;
    end else if (run) begin
      rem      <= CNT_W'(ge ? diff : sh);
      quotient <= {quotient[ACC_W-2:0], ge};
      cnt      <= cnt - CW'(1);
      if (done) run <= 1'b0;
    end
  end

endmodule

// File: rtl/mean_reduce_unit.sv
// Streaming per-channel MEAN with round-half-away-from-zero division.
// Optional zero-point support is compiled in with `define MEAN_ZP_EN.
import mean_pkg::*;

module mean_reduce_unit #(
  parameter int DATA_W = 8,
  parameter int MAX_CH = 64,
  parameter int CNT_W  = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [$clog2(MAX_CH+1)-1:0] cfg_num_ch,
  input  logic [CNT_W-1:0]            cfg_num_spatial,
`ifdef MEAN_ZP_EN
  input  logic [DATA_W-1:0]           cfg_in_zp,
  input  logic [DATA_W-1:0]           cfg_out_zp,
`endif
  output logic                        busy,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [DATA_W-1:0]           in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_W-1:0]           out_data,
  output logic [$clog2(MAX_CH)-1:0]   out_ch,
  output logic                        done,
  output logic                        err
);
`ifdef MEAN_ZP_EN
  localparam bit ZP_EN = 1'b1;
`else
  localparam bit ZP_EN = 1'b0;
`endif
  localparam int CHW   = $clog2(MAX_CH + 1);
  localparam int OCW   = $clog2(MAX_CH);
  localparam int ACC_W = acc_w_f(DATA_W, CNT_W, ZP_EN);

  state_t state, state_nx;

  logic [CHW-1:0]          num_ch;
  logic [CNT_W-1:0]        num_sp;
  logic [OCW-1:0]          ch;
  logic [CNT_W-1:0]        pos;
  logic                    div_ld;
  logic signed [ACC_W-1:0] acc [MAX_CH];

  logic                    cfg_bad, beat, last_ch, last_pos, div_done;
  logic signed [ACC_W-1:0] elem_ext, acc_sel;
  logic [ACC_W-1:0]        mag, dividend, quot;
  logic signed [ACC_W+1:0] q_s, q_z;

  assign cfg_bad  = (cfg_num_ch == '0) || (cfg_num_ch > CHW'(MAX_CH)) || (cfg_num_spatial == '0);
  assign beat     = in_valid && (state == ACCUM);
  assign last_ch  = (CHW'(ch) == num_ch - CHW'(1));
  assign last_pos = (pos == num_sp - CNT_W'(1));

  assign busy      = (state != IDLE);
  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == OUTPUT);
  assign done      = (state == DONE);

`ifdef MEAN_ZP_EN
  logic [DATA_W-1:0]       in_zp, out_zp;
  logic signed [DATA_W:0]  elem_d;
  assign elem_d   = $signed({in_data[DATA_W-1], in_data}) - $signed({in_zp[DATA_W-1], in_zp});
  assign elem_ext = ACC_W'(elem_d);
`else
  assign elem_ext = ACC_W'($signed(in_data));
`endif

  // Sign is taken from the accumulator itself; it stays untouched through DIVIDE and OUTPUT.
  assign acc_sel  = acc[ch];
  assign mag      = acc_sel[ACC_W-1] ? $unsigned(-acc_sel) : $unsigned(acc_sel);
  assign dividend = mag + ACC_W'(rnd_half(longint'(num_sp)));
  assign q_s      = acc_sel[ACC_W-1] ? -$signed({2'b00, quot}) : $signed({2'b00, quot});

`ifdef MEAN_ZP_EN
  assign q_z = q_s + (ACC_W+2)'($signed(out_zp));
`else
  assign q_z = q_s;
`endif

  always_comb begin
    out_data = '0;
    out_ch   = '0;
    if (state == OUTPUT) begin
      out_data = DATA_W'(sat_narrow(longint'(q_z), DATA_W));
      out_ch   = ch;
    end
  end

  mean_div_seq #(.ACC_W(ACC_W), .CNT_W(CNT_W)) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (div_ld),
    .dividend (dividend),
    .divisor  (num_sp),
    .quotient (quot),
    .done     (div_done)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = cfg_bad ? DONE : ACCUM;
      ACCUM:   if (beat && last_ch && last_pos) state_nx = DIVIDE;
      DIVIDE:  if (div_done) state_nx = OUTPUT;
      OUTPUT:  if (out_ready) state_nx = last_ch ? DONE : DIVIDE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      num_ch <= '0;
      num_sp <= '0;
      ch     <= '0;
      pos    <= '0;
      div_ld <= 1'b0;
      err    <= 1'b0;
      for (int i = 0; i < MAX_CH; i++) acc[i] <= '0;
`ifdef MEAN_ZP_EN
      in_zp  <= '0;
      out_zp <= '0;
`endif
    end else begin
      // Divider load happens in the first DIVIDE cycle, once acc[ch] has settled.
      div_ld <= (state_nx == DIVIDE) && (state != DIVIDE);
      case (state)
        IDLE: if (start) begin
          num_ch <= cfg_num_ch;
          num_sp <= cfg_num_spatial;
          err    <= cfg_bad;
          ch     <= '0;
          pos    <= '0;
          for (int i = 0; i < MAX_CH; i++)
            if (i < int'(cfg_num_ch)) acc[i] <= '0;
`ifdef MEAN_ZP_EN
          in_zp  <= cfg_in_zp;
          out_zp <= cfg_out_zp;
`endif
        end
        ACCUM: if (beat) begin
          acc[ch] <= acc[ch] + elem_ext;
          if (last_ch) begin
            ch  <= '0;
            pos <= pos + CNT_W'(1);
          end else begin
            ch  <= ch + OCW'(1);
          end
        end
        OUTPUT: if (out_ready && !last_ch) ch <= ch + OCW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mean_reduce_unit.sv
// Scoreboard bench for mean_reduce_unit: expected means queued at stimulus time, compared on output handshakes.
module tb_mean_reduce_unit;
  localparam int DATA_W = 8;
  localparam int MAX_CH = 64;
  localparam int CNT_W  = 16;
`ifdef MEAN_ZP_EN
  localparam int LAT = DATA_W + CNT_W + 1 + 2;
`else
  localparam int LAT = DATA_W + CNT_W + 2;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [6:0]        cfg_num_ch = '0;
  logic [CNT_W-1:0]  cfg_num_spatial = '0;
  logic              busy, in_ready, out_valid, done, err;
  logic              in_valid = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              out_ready = 1'b0;
  logic [DATA_W-1:0] out_data;
  logic [5:0]        out_ch;
`ifdef MEAN_ZP_EN
  logic [DATA_W-1:0] cfg_in_zp = '0;
  logic [DATA_W-1:0] cfg_out_zp = '0;
`endif

  mean_reduce_unit #(.DATA_W(DATA_W), .MAX_CH(MAX_CH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .cfg_num_ch(cfg_num_ch), .cfg_num_spatial(cfg_num_spatial),
`ifdef MEAN_ZP_EN
    .cfg_in_zp(cfg_in_zp), .cfg_out_zp(cfg_out_zp),
`endif
    .busy(busy), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ch(out_ch),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int exp_d[$];
  int exp_c[$];
  int din[$];

  function automatic int mean_rnd(input longint s, input longint n);
    longint m;
    m = ((s < 0 ? -s : s) + n / 2) / n;
    m = (s < 0) ? -m : m;
    if (m > 127) m = 127;
    if (m < -128) m = -128;
    return int'(m);
  endfunction

  // Starts a job, streams din[], and queues the expected mean for each channel.
  task automatic feed(input int nch, input int nsp, input bit toggle);
    longint sum [MAX_CH];
    int idx, budget;
    bit ph, hs;
    for (int c = 0; c < MAX_CH; c++) sum[c] = 0;
    for (int k = 0; k < din.size(); k++) sum[k % nch] += din[k];
    for (int c = 0; c < nch; c++) begin
      exp_d.push_back(mean_rnd(sum[c], nsp));
      exp_c.push_back(c);
    end
    @(negedge clk);
    start = 1'b1; cfg_num_ch = 7'(nch); cfg_num_spatial = CNT_W'(nsp);
    @(negedge clk);
    start = 1'b0;
    idx = 0; ph = 1'b1; budget = 4 * din.size() + 100;
    while (idx < din.size() && budget > 0) begin
      in_valid = toggle ? ph : 1'b1;
      ph = !ph;
      in_data = DATA_W'(din[idx]);
      hs = in_valid && in_ready;
      @(negedge clk);
      if (hs) idx++;
      budget--;
    end
    in_valid = 1'b0;
    total++;
    if (idx != din.size()) begin
      bad++;
      $display("FAIL feed_beats got=%0d want=%0d", idx, din.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({busy, in_ready, out_valid, done, err} !== 5'b0) begin
      bad++; $display("FAIL reset_ctrl got=%b want=00000", {busy, in_ready, out_valid, done, err});
    end
    total++;
    if ({out_data, out_ch} !== 14'b0) begin
      bad++; $display("FAIL reset_data got=%h/%0d want=0/0", out_data, out_ch);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int lat, d, c;
    din = {1, 2, 3, 4};
    feed(1, 4, 1'b0);
    lat = 1;
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_early_valid got=%b want=0", out_valid); end
    while (!out_valid && lat < 200) begin @(negedge clk); lat++; end
    total++;
    if (lat != LAT) begin bad++; $display("FAIL basic_latency got=%0d want=%0d", lat, LAT); end
    out_ready = 1'b1;
    d = exp_d.pop_front(); c = exp_c.pop_front();
    total++;
    if (int'($signed(out_data)) !== d || int'(out_ch) !== c) begin
      bad++; $display("FAIL basic_data got=%0d/%0d want=%0d/%0d", $signed(out_data), out_ch, d, c);
    end
    @(negedge clk);
    out_ready = 1'b0;
    total++;
    if (done !== 1'b1 || out_valid !== 1'b0) begin
      bad++; $display("FAIL basic_done got=%b/%b want=1/0", done, out_valid);
    end
    @(negedge clk);
    total++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL basic_idle got=%b/%b want=0/0", done, busy);
    end
  endtask

  // Collects nres results with out_ready held high; final check on the done pulse.
  task automatic test_neg_round();
    int got, budget, d, c;
    din = {-3, 5, -2, 6};
    feed(2, 2, 1'b0);
    out_ready = 1'b1; got = 0; budget = 200;
    while (got < 2 && budget > 0) begin
      if (out_valid) begin
        d = exp_d.pop_front(); c = exp_c.pop_front();
        total++;
        if (int'($signed(out_data)) !== d || int'(out_ch) !== c) begin
          bad++; $display("FAIL neg_data got=%0d/%0d want=%0d/%0d", $signed(out_data), out_ch, d, c);
        end
        got++;
      end
      @(negedge clk); budget--;
    end
    out_ready = 1'b0;
    total++;
    if (got != 2 || done !== 1'b1) begin
      bad++; $display("FAIL neg_count got=%0d/%b want=2/1", got, done);
    end
    @(negedge clk);
  endtask

  task automatic test_saturation();
    int budget;
    din.delete();
    for (int k = 0; k < 65535; k++) din.push_back(-128);
    feed(1, 65535, 1'b0);
    budget = 200;
    while (!out_valid && budget > 0) begin @(negedge clk); budget--; end
    total++;
    if (!out_valid || int'($signed(out_data)) !== exp_d[0]) begin
      bad++; $display("FAIL sat_data got=%0d/%b want=%0d/1", $signed(out_data), out_valid, exp_d[0]);
    end
    void'(exp_d.pop_front()); void'(exp_c.pop_front());
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    total++;
    if (done !== 1'b1) begin bad++; $display("FAIL sat_done got=%b want=1", done); end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    int hs, budget, d, c;
    logic [DATA_W-1:0] d0;
    logic [5:0] c0;
    din.delete();
    for (int k = 0; k < 9; k++) din.push_back($signed(8'($urandom_range(0, 255))));
    feed(3, 3, 1'b1);
    hs = 0; budget = 400;
    while (hs < 3 && budget > 0) begin
      if (out_valid) begin
        d0 = out_data; c0 = out_ch;
        for (int s = 0; s < 5; s++) begin
          @(negedge clk);
          total++;
          if (out_valid !== 1'b1 || out_data !== d0 || out_ch !== c0) begin
            bad++; $display("FAIL bp_stable got=%b/%0d/%0d want=1/%0d/%0d", out_valid, out_data, out_ch, d0, c0);
          end
        end
        d = exp_d.pop_front(); c = exp_c.pop_front();
        total++;
        if (int'($signed(out_data)) !== d || int'(out_ch) !== c) begin
          bad++; $display("FAIL bp_data got=%0d/%0d want=%0d/%0d", $signed(out_data), out_ch, d, c);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        hs++;
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_drop got=%b want=0", out_valid); end
      end else begin
        @(negedge clk); budget--;
      end
    end
    total++;
    if (hs != 3 || done !== 1'b1) begin bad++; $display("FAIL bp_count got=%0d/%b want=3/1", hs, done); end
    repeat (4) begin
      @(negedge clk);
      total++;
      if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_extra got=%b want=0", out_valid); end
    end
  endtask

  task automatic test_cfg_err();
    int nch [2] = '{1, MAX_CH + 1};
    int nsp [2] = '{0, 4};
    int budget;
    for (int t = 0; t < 2; t++) begin
      @(negedge clk);
      start = 1'b1; cfg_num_ch = 7'(nch[t]); cfg_num_spatial = CNT_W'(nsp[t]);
      @(negedge clk);
      start = 1'b0;
      total++;
      if ({done, err, out_valid} !== 3'b110) begin
        bad++; $display("FAIL err_pulse%0d got=%b want=110", t, {done, err, out_valid});
      end
      @(negedge clk);
      total++;
      if ({done, err, busy, out_valid} !== 4'b0100) begin
        bad++; $display("FAIL err_after%0d got=%b want=0100", t, {done, err, busy, out_valid});
      end
    end
    din = {7, 8};
    feed(1, 2, 1'b0);
    total++;
    if (err !== 1'b0) begin bad++; $display("FAIL err_clear got=%b want=0", err); end
    budget = 200;
    while (!out_valid && budget > 0) begin @(negedge clk); budget--; end
    total++;
    if (int'($signed(out_data)) !== exp_d[0] || out_valid !== 1'b1) begin
      bad++; $display("FAIL err_rerun got=%0d want=%0d", $signed(out_data), exp_d[0]);
    end
    void'(exp_d.pop_front()); void'(exp_c.pop_front());
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int got, budget, d, c;
    din = {100, -100, 90, -90};
    feed(2, 2, 1'b0);
    repeat (5) @(negedge clk);
    total++;
    if (busy !== 1'b1 || out_valid !== 1'b0) begin
      bad++; $display("FAIL rst_in_divide got=%b/%b want=1/0", busy, out_valid);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    total++;
    if ({busy, out_valid, done} !== 3'b000) begin
      bad++; $display("FAIL rst_abort got=%b want=000", {busy, out_valid, done});
    end
    exp_d.delete(); exp_c.delete();
    repeat (40) begin
      @(negedge clk);
      total++;
      if (out_valid !== 1'b0 || done !== 1'b0) begin
        bad++; $display("FAIL rst_quiet got=%b/%b want=0/0", out_valid, done);
      end
    end
    din = {-1, 3, -2, 4};
    feed(2, 2, 1'b0);
    out_ready = 1'b1; got = 0; budget = 200;
    while (got < 2 && budget > 0) begin
      if (out_valid) begin
        d = exp_d.pop_front(); c = exp_c.pop_front();
        total++;
        if (int'($signed(out_data)) !== d || int'(out_ch) !== c) begin
          bad++; $display("FAIL rst_rerun got=%0d/%0d want=%0d/%0d", $signed(out_data), out_ch, d, c);
        end
        got++;
      end
      @(negedge clk); budget--;
    end
    out_ready = 1'b0;
    total++;
    if (got != 2) begin bad++; $display("FAIL rst_rerun_count got=%0d want=2", got); end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_neg_round();
    test_backpressure();
    test_cfg_err();
    test_reset_mid();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
